// File: rtl/core_block_ctrl.sv
// Core-side block dispatch endpoint: splits an assigned block into warps, issues them
// over valid/ready, counts retirements and pulses core_done once per block.
module core_block_ctrl #(
    parameter int unsigned WARP_SIZE   = 32,
    parameter int unsigned MAX_THREADS = 1024,
    parameter int unsigned WARP_W      = $clog2(MAX_THREADS / WARP_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_start,
    input  logic [31:0]          block_id,
    input  logic [31:0]          threads_per_block,
    output logic                 warp_valid,
    input  logic                 warp_ready,
    output logic [WARP_W-1:0]    warp_id,
    output logic [31:0]          warp_base_thread,
    output logic [WARP_SIZE-1:0] warp_mask,
    input  logic                 warp_retire,
    output logic                 core_done,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned LANE_W = $clog2(WARP_SIZE);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [31:0]          blk_q, blk_d;
    logic [31:0]          tpb_q, tpb_d;
    logic [WARP_W-1:0]    num_warps_q, num_warps_d;
    logic [LANE_W-1:0]    tail_q, tail_d;
    logic [WARP_W-1:0]    issued_q, issued_d;
    logic [WARP_W-1:0]    retired_q, retired_d;
    logic [31:0]          base_out_d;
    logic [WARP_SIZE-1:0] mask_d;
    logic                 err_d;

    logic [LANE_W-1:0]    tail_c;
    logic [WARP_W-1:0]    nw_c;

    // Mask for the last warp: partial when the block size is not a warp multiple.
    function automatic logic [WARP_SIZE-1:0] lane_mask(input logic [LANE_W-1:0] t);
        if (t == '0) return '1;
        return (WARP_SIZE'(1) << t) - WARP_SIZE'(1);
    endfunction

    assign tail_c  = tpb_q[LANE_W-1:0];
    assign nw_c    = WARP_W'(tpb_q >> LANE_W) + WARP_W'(|tail_c);
    assign warp_id = issued_q;

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        tpb_d       = tpb_q;
        num_warps_d = num_warps_q;
        tail_d      = tail_q;
        issued_d    = issued_q;
        retired_d   = retired_q;
        base_out_d  = warp_base_thread;
        mask_d      = warp_mask;
        err_d       = err;

        // Retirements are only legal while warps can be outstanding.
        if (warp_retire) begin
            if ((state_q == S_ISSUE || state_q == S_DRAIN) && retired_q != issued_q)
                retired_d = retired_q + WARP_W'(1);
            else
                err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (core_start) begin
                    blk_d   = block_id;
                    tpb_d   = threads_per_block;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                num_warps_d = nw_c;
                tail_d      = tail_c;
                issued_d    = '0;
                retired_d   = '0;
                if (tpb_q == 32'd0) begin
                    state_d = S_DONE;
                end else if (tpb_q > 32'(MAX_THREADS)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    base_out_d = 32'(blk_q * tpb_q);
                    mask_d     = (nw_c == WARP_W'(1)) ? lane_mask(tail_c) : '1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (warp_ready) begin
                    issued_d = issued_q + WARP_W'(1);
                    if (issued_q == num_warps_q - WARP_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        base_out_d = warp_base_thread + 32'(WARP_SIZE);
                        mask_d     = (issued_d == num_warps_q - WARP_W'(1)) ? lane_mask(tail_q) : '1;
                    end
                end
            end
            S_DRAIN: begin
                if (retired_d == num_warps_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!core_start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            blk_q            <= '0;
            tpb_q            <= '0;
            num_warps_q      <= '0;
            tail_q           <= '0;
            issued_q         <= '0;
            retired_q        <= '0;
            warp_valid       <= 1'b0;
            warp_base_thread <= '0;
            warp_mask        <= '0;
            core_done        <= 1'b0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state_q          <= state_d;
            blk_q            <= blk_d;
            tpb_q            <= tpb_d;
            num_warps_q      <= num_warps_d;
            tail_q           <= tail_d;
            issued_q         <= issued_d;
            retired_q        <= retired_d;
            warp_valid       <= (state_d == S_ISSUE);
            warp_base_thread <= base_out_d;
            warp_mask        <= mask_d;
            core_done        <= (state_d == S_DONE);
            busy             <= (state_d != S_IDLE);
            err              <= err_d;
        end
    end
endmodule

// File: tb/tb_core_block_ctrl.sv
// Directed bench for core_block_ctrl: warp fields, handshake stalls, completion timing and errors.
module tb_core_block_ctrl;
    localparam int unsigned WARP_SIZE   = 32;
    localparam int unsigned MAX_THREADS = 1024;
    localparam int unsigned WARP_W      = 6;

    logic                 clk = 1'b0;
    logic                 reset, core_start, warp_valid, warp_ready, warp_retire, core_done, busy, err;
    logic [31:0]          block_id, threads_per_block, warp_base_thread;
    logic [WARP_W-1:0]    warp_id;
    logic [WARP_SIZE-1:0] warp_mask;

    core_block_ctrl #(.WARP_SIZE(WARP_SIZE), .MAX_THREADS(MAX_THREADS)) dut (
        .clk(clk), .reset(reset), .core_start(core_start), .block_id(block_id),
        .threads_per_block(threads_per_block), .warp_valid(warp_valid), .warp_ready(warp_ready),
        .warp_id(warp_id), .warp_base_thread(warp_base_thread), .warp_mask(warp_mask),
        .warp_retire(warp_retire), .core_done(core_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_pass = 0, cyc = 0;
    int          start_cyc, ret_dly, n_ret, first_valid_cyc, last_ret, n_acc, n_done;
    int          acc_id[$];
    logic [31:0] acc_base[$];
    logic [31:0] acc_mask[$];
    int          done_cyc[$];
    int          ret_due[$];
    bit          timed_out;

    // One clock: log the accept about to happen, advance, then drive scheduled retires.
    task automatic step();
        if (warp_valid && warp_ready) begin
            acc_id.push_back(int'(warp_id));
            acc_base.push_back(warp_base_thread);
            acc_mask.push_back(warp_mask);
            ret_due.push_back(cyc + 1 + ret_dly);
        end
        @(posedge clk); #1; cyc++;
        warp_retire = 1'b0;
        if (ret_due.size() != 0 && ret_due[0] == cyc) begin
            void'(ret_due.pop_front());
            warp_retire = 1'b1;
            last_ret = cyc;
            n_ret++;
        end
        if (core_done) done_cyc.push_back(cyc);
        if (warp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    endtask

    task automatic start_block(input logic [31:0] tpb, input logic [31:0] bid, input int dly);
        acc_id.delete(); acc_base.delete(); acc_mask.delete(); done_cyc.delete(); ret_due.delete();
        n_ret = 0; first_valid_cyc = -1; last_ret = -100; ret_dly = dly;
        threads_per_block = tpb; block_id = bid; core_start = 1'b1; warp_ready = 1'b1;
        warp_retire = 1'b0; start_cyc = cyc;
    endtask

    task automatic finish_block(input bit keep);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done_cyc.size() != 0) begin timed_out = 1'b0; break; end
        end
        for (int i = 0; i < 4; i++) step();
        if (keep) begin
            n_checks++;
            if (busy !== 1'b1 || warp_valid !== 1'b0)
                $display("FAIL release_hold: busy=%0b valid=%0b required busy=1 valid=0", busy, warp_valid);
            else n_pass++;
        end
        core_start = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_return: busy=%0b required 0", busy);
        else n_pass++;
        n_acc = acc_id.size(); n_done = done_cyc.size();
        while (acc_id.size() < 4) begin
            acc_id.push_back(-1); acc_base.push_back(32'hxxxx_xxxx); acc_mask.push_back(32'hxxxx_xxxx);
        end
        while (done_cyc.size() < 2) done_cyc.push_back(-999);
        n_checks++;
        if (timed_out !== 1'b0) $display("FAIL done_timeout: no core_done within budget");
        else n_pass++;
    endtask

    task automatic run_block(input logic [31:0] tpb, input logic [31:0] bid, input int dly, input bit drop);
        start_block(tpb, bid, dly);
        if (drop) begin
            step(); step();
            core_start = 1'b0;
            block_id = 32'hffff_0000;
        end
        finish_block(!drop);
    endtask

    task automatic test_reset();
        reset = 1'b1; core_start = 1'b0; block_id = '0; threads_per_block = '0;
        warp_ready = 1'b0; warp_retire = 1'b0; ret_dly = 1; first_valid_cyc = -1;
        step(); step();
        n_checks++;
        if ({warp_valid, core_done, busy, err} !== 4'b0000)
            $display("FAIL reset_flags: v/d/b/e=%b required 0000", {warp_valid, core_done, busy, err});
        else n_pass++;
        n_checks++;
        if (warp_id !== '0 || warp_base_thread !== 32'd0 || warp_mask !== 32'd0)
            $display("FAIL reset_fields: id=%0d base=%0h mask=%0h required 0", warp_id, warp_base_thread, warp_mask);
        else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_block(32'd64, 32'd3, 2, 1'b0);
        n_checks++;
        if (n_acc !== 2) $display("FAIL basic_count: accepts=%0d required 2", n_acc); else n_pass++;
        n_checks++;
        if (acc_id[0] !== 0 || acc_base[0] !== 32'd192 || acc_mask[0] !== 32'hffff_ffff)
            $display("FAIL basic_w0: id=%0d base=%0d mask=%0h required 0/192/ffffffff", acc_id[0], acc_base[0], acc_mask[0]);
        else n_pass++;
        n_checks++;
        if (acc_id[1] !== 1 || acc_base[1] !== 32'd224 || acc_mask[1] !== 32'hffff_ffff)
            $display("FAIL basic_w1: id=%0d base=%0d mask=%0h required 1/224/ffffffff", acc_id[1], acc_base[1], acc_mask[1]);
        else n_pass++;
        n_checks++;
        if (first_valid_cyc !== start_cyc + 2)
            $display("FAIL basic_first_valid: cycle=%0d required %0d", first_valid_cyc, start_cyc + 2);
        else n_pass++;
        n_checks++;
        if (n_done !== 1 || done_cyc[0] !== last_ret + 1)
            $display("FAIL basic_done: pulses=%0d at=%0d required 1 at %0d", n_done, done_cyc[0], last_ret + 1);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL basic_err: err=%0b required 0", err); else n_pass++;
    endtask

    task automatic test_tail();
        run_block(32'd40, 32'd1, 1, 1'b1);
        n_checks++;
        if (n_acc !== 2 || acc_base[0] !== 32'd40 || acc_mask[0] !== 32'hffff_ffff)
            $display("FAIL tail_w0: n=%0d base=%0d mask=%0h required 2/40/ffffffff", n_acc, acc_base[0], acc_mask[0]);
        else n_pass++;
        n_checks++;
        if (acc_base[1] !== 32'd72 || acc_mask[1] !== 32'h0000_00ff)
            $display("FAIL tail_w1: base=%0d mask=%0h required 72/000000ff", acc_base[1], acc_mask[1]);
        else n_pass++;
        n_checks++;
        if (n_done !== 1 || n_ret !== 2 || done_cyc[0] !== last_ret + 1)
            $display("FAIL tail_done: pulses=%0d retires=%0d at=%0d required 1/2/%0d", n_done, n_ret, done_cyc[0], last_ret + 1);
        else n_pass++;
    endtask

    task automatic test_stall();
        int guard;
        start_block(32'd96, 32'd2, 1);
        guard = 0;
        while (!(warp_valid && warp_id == WARP_W'(1)) && guard < 50) begin step(); guard++; end
        n_checks++;
        if (guard >= 50) $display("FAIL stall_reach: warp1 never presented"); else n_pass++;
        warp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (warp_valid !== 1'b1 || warp_id !== WARP_W'(1) || warp_base_thread !== 32'd224 || warp_mask !== 32'hffff_ffff)
                $display("FAIL stall_hold: v=%0b id=%0d base=%0d mask=%0h required 1/1/224/ffffffff",
                         warp_valid, warp_id, warp_base_thread, warp_mask);
            else n_pass++;
        end
        warp_ready = 1'b1;
        finish_block(1'b1);
        n_checks++;
        if (n_acc !== 3 || acc_id[0] !== 0 || acc_id[1] !== 1 || acc_id[2] !== 2)
            $display("FAIL stall_ids: n=%0d ids=%0d,%0d,%0d required 3 with 0,1,2", n_acc, acc_id[0], acc_id[1], acc_id[2]);
        else n_pass++;
        n_checks++;
        if (acc_base[2] !== 32'd256 || n_done !== 1)
            $display("FAIL stall_w2: base=%0d pulses=%0d required 256/1", acc_base[2], n_done);
        else n_pass++;
    endtask

    task automatic test_zero_and_oversize();
        run_block(32'd0, 32'd5, 1, 1'b0);
        n_checks++;
        if (n_acc !== 0 || first_valid_cyc !== -1 || done_cyc[0] !== start_cyc + 2 || err !== 1'b0)
            $display("FAIL zero_tpb: acc=%0d valid_at=%0d done_at=%0d err=%0b required 0/-1/%0d/0",
                     n_acc, first_valid_cyc, done_cyc[0], err, start_cyc + 2);
        else n_pass++;
        run_block(32'd2048, 32'd1, 1, 1'b0);
        n_checks++;
        if (n_acc !== 0 || first_valid_cyc !== -1 || done_cyc[0] !== start_cyc + 2 || err !== 1'b1)
            $display("FAIL oversize: acc=%0d valid_at=%0d done_at=%0d err=%0b required 0/-1/%0d/1",
                     n_acc, first_valid_cyc, done_cyc[0], err, start_cyc + 2);
        else n_pass++;
    endtask

    task automatic test_errors();
        int guard;
        reset = 1'b1; step(); reset = 1'b0; step();
        warp_retire = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL retire_idle: err=%0b busy=%0b required 1/0", err, busy);
        else n_pass++;
        reset = 1'b1; step(); reset = 1'b0; step();
        start_block(32'd64, 32'd0, 1);
        warp_ready = 1'b0;
        guard = 0;
        while (!warp_valid && guard < 20) begin step(); guard++; end
        warp_retire = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b1) $display("FAIL retire_none: err=%0b required 1", err); else n_pass++;
        warp_ready = 1'b1;
        finish_block(1'b1);
        n_checks++;
        if (n_acc !== 2 || n_done !== 1 || done_cyc[0] !== last_ret + 1 || err !== 1'b1)
            $display("FAIL retire_none_counts: acc=%0d pulses=%0d done_at=%0d err=%0b required 2/1/%0d/1",
                     n_acc, n_done, done_cyc[0], err, last_ret + 1);
        else n_pass++;
        run_block(32'd64, 32'd7, 1, 1'b0);
        n_checks++;
        if (acc_base[0] !== 32'd448 || acc_base[1] !== 32'd480 || err !== 1'b1)
            $display("FAIL relaunch: base0=%0d base1=%0d err=%0b required 448/480/1", acc_base[0], acc_base[1], err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard;
        start_block(32'd64, 32'd3, 20);
        guard = 0;
        while (acc_id.size() < 1 && guard < 20) begin step(); guard++; end
        warp_ready = 1'b0; core_start = 1'b0; reset = 1'b1;
        ret_due.delete();
        step();
        reset = 1'b0;
        n_checks++;
        if ({warp_valid, core_done, busy, err} !== 4'b0000 || warp_id !== '0 ||
            warp_base_thread !== 32'd0 || warp_mask !== 32'd0)
            $display("FAIL reset_mid: v/d/b/e=%b id=%0d base=%0h mask=%0h required all 0",
                     {warp_valid, core_done, busy, err}, warp_id, warp_base_thread, warp_mask);
        else n_pass++;
        run_block(32'd64, 32'd3, 1, 1'b0);
        n_checks++;
        if (n_acc !== 2 || acc_id[0] !== 0 || acc_base[0] !== 32'd192 || acc_id[1] !== 1)
            $display("FAIL reset_reissue: n=%0d id0=%0d base0=%0d id1=%0d required 2/0/192/1",
                     n_acc, acc_id[0], acc_base[0], acc_id[1]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tail();
        test_stall();
        test_zero_and_oversize();
        test_errors();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/core_block_ctrl.md
Name: core_block_ctrl

Overview:
Core-side endpoint of block dispatch, one instance per core. It accepts a block assignment (the core's in-use bit plus its block id), splits the block into warps, and issues them to the core's execution pipeline over a valid/ready handshake. It counts warp retirements and returns a single-cycle core_done pulse to the dispatcher. It then waits for the dispatcher to drop the in-use bit before it accepts another block.

Parameters:
WARP_SIZE, 32, threads per warp; power of two, at least 2.
MAX_THREADS, 1024, largest legal threads_per_block; multiple of WARP_SIZE.
WARP_W, $clog2(MAX_THREADS/WARP_SIZE)+1, width of the warp counters (derived).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
core_start  input  1  this core's in-use bit from the dispatcher; level-sensitive.
block_id  input  32  block id assigned to this core; valid while core_start=1.
threads_per_block  input  32  from kernel config; stable for the whole kernel.
warp_valid  output  1  a warp descriptor is presented.
warp_ready  input  1  the pipeline accepts the descriptor.
warp_id  output  WARP_W  warp index within the block.
warp_base_thread  output  32  global thread id of lane 0.
warp_mask  output  WARP_SIZE  active-lane mask; bit i = lane i.
warp_retire  input  1  one-cycle pulse; one issued warp has completed.
core_done  output  1  one-cycle pulse; the block is complete.
busy  output  1  high in every state except IDLE.
err  output  1  sticky protocol/config error; cleared only by reset.

Behaviour:
- Reset (sync, high): state=IDLE. All outputs 0. All counters 0. Latched block id 0. Reset wins over every other event in the same cycle, in any state.
- States: IDLE, LAUNCH, ISSUE, DRAIN, DONE, RELEASE.
- IDLE: when core_start=1, latch block_id and threads_per_block, then go to LAUNCH. Later changes on block_id are ignored until the next IDLE.
- LAUNCH (1 cycle):
  - Register num_warps = ceil(tpb/WARP_SIZE).
  - Register base = block_id*tpb, truncated mod 2^32.
  - Register tail = tpb mod WARP_SIZE.
  - If tpb=0: go to DONE with no warps issued.
  - If tpb>MAX_THREADS: set err, go to DONE with no warps issued.
  - Otherwise go to ISSUE with issued=0 and retired=0.
- ISSUE:
  - warp_valid=1. warp_id=issued. warp_base_thread = base + issued*WARP_SIZE (mod 2^32).
  - warp_mask is all ones, except on the last warp when tail!=0, where it is (1<<tail)-1.
  - Outputs hold stable while warp_ready=0.
  - On warp_valid & warp_ready: issued++. If that was warp num_warps-1, go to DRAIN the next cycle.
  - Back-to-back issue is allowed: one warp per cycle while ready stays high.
- Retirement is counted in ISSUE and DRAIN.
  - A warp_retire in the same cycle as an accept counts only against warps issued before that cycle.
  - warp_retire with retired==issued (that is, nothing outstanding, counting only warps issued before that cycle) is ignored and sets err.
  - warp_retire in IDLE, LAUNCH, DONE or RELEASE is ignored and sets err.
- DRAIN: warp_valid=0. When retired+warp_retire reaches num_warps, go to DONE the next cycle.
- DONE (1 cycle): core_done=1, then go to RELEASE.
- RELEASE:
  - core_done=0. Stay until core_start=0, then go to IDLE.
  - This prevents a stale in-use bit from restarting the same block.
  - Minimum gap from the core_done cycle to the next LAUNCH is 3 cycles.
- Latency with warp_ready=1 and retirements immediate:
  - start→first warp_valid: 2 cycles.
  - Last retire→core_done: 1 cycle.
- busy=1 in LAUNCH through RELEASE.
- core_start dropping mid-block is ignored: the block runs to completion.

Test Plan:
- tpb=64, block_id=3, ready=1, retire 2 cycles after each accept → warps (id0,base 192,mask all ones), (id1,base 224,mask all ones); core_done exactly one cycle after the 2nd retire; core_done is a single pulse.
- tpb=40, block_id=1 → warp0 base 40 mask 0xFFFFFFFF; warp1 base 72 mask 0x000000FF; core_done after 2 retires.
- tpb=96, warp_ready low 5 cycles on warp1 → warp1 fields held constant; exactly 3 accepts with ids 0,1,2; no duplicate issue.
- tpb=0 → core_done 2 cycles after core_start rises; warp_valid never asserts. tpb=2048 → err=1 and core_done, no warps issued.
- Retire pulse with nothing outstanding, and retire in IDLE → err=1 and sticky; counts unchanged. Keep core_start=1 after core_done → stays in RELEASE, no relaunch; drop core_start → IDLE; re-raise core_start with block_id=7 → base 7*tpb.
- Assert reset mid-ISSUE (after 1 accept) → next cycle: IDLE, all outputs 0, err cleared; the following start re-issues from warp 0.
